// File: rtl/pcs_pkg.sv
// Shared PCS definitions: block-lock FSM states and 64b/66b sync header values.
// Also provides sh_valid(): 1 for the two legal sync headers, 0 for 2'b00 and 2'b11.
// No ports; this package is imported by the PCS receive blocks.
package pcs_pkg;

    typedef enum logic [1:0] {
        TEST = 2'd0,
        SLIP = 2'd1,
        WAIT = 2'd2
    } bl_state_t;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    function automatic logic sh_valid(input logic [1:0] head);
        return (head == SYNC_DATA) || (head == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/block_lock_64b66b.sv
// Receive-side 64b/66b block-lock FSM. It judges sync headers from the gearbox and
// pulses slip_o until header alignment is found, then asserts block_lock_o.
// Ports: clk_i/rst_i (async active-high); head_i/head_valid_i come from the gearbox;
//        slip_o, block_lock_o and slip_cnt_o are all registered outputs.
module block_lock_64b66b
    import pcs_pkg::*;
#(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 32,
    parameter int SLIP_CNT_W   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            head_i,
    input  logic                  head_valid_i,
    output logic                  slip_o,
    output logic                  block_lock_o,
    output logic [SLIP_CNT_W-1:0] slip_cnt_o
);

    localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SH_CNT_MAX);
    localparam logic [CNT_W-1:0]  INVLD_MAX = CNT_W'(SH_INVLD_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    bl_state_t             r_state,     w_state_nxt;
    logic [CNT_W-1:0]      r_sh_cnt,    w_sh_cnt_nxt;
    logic [CNT_W-1:0]      r_invld_cnt, w_invld_cnt_nxt;
    logic [WAIT_W-1:0]     r_wait_cnt,  w_wait_cnt_nxt;
    logic                  r_slip,      w_slip_nxt;
    logic                  r_lock,      w_lock_nxt;
    logic [SLIP_CNT_W-1:0] r_slip_cnt,  w_slip_cnt_nxt;

    logic                  w_head_bad;
    logic [CNT_W-1:0]      w_sh_cnt_inc;
    logic [CNT_W-1:0]      w_invld_inc;
    logic                  w_go_slip;

    assign w_head_bad   = !sh_valid(head_i);
    assign w_sh_cnt_inc = r_sh_cnt + CNT_W'(1);
    assign w_invld_inc  = r_invld_cnt + CNT_W'(w_head_bad);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= TEST;
            r_sh_cnt    <= '0;
            r_invld_cnt <= '0;
            r_wait_cnt  <= '0;
            r_slip      <= 1'b0;
            r_lock      <= 1'b0;
            r_slip_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sh_cnt    <= w_sh_cnt_nxt;
            r_invld_cnt <= w_invld_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_slip      <= w_slip_nxt;
            r_lock      <= w_lock_nxt;
            r_slip_cnt  <= w_slip_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sh_cnt_nxt    = r_sh_cnt;
        w_invld_cnt_nxt = r_invld_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_slip_nxt      = 1'b0;
        w_lock_nxt      = r_lock;
        w_slip_cnt_nxt  = r_slip_cnt;
        w_go_slip       = 1'b0;

        case (r_state)
            TEST: begin
                if (head_valid_i) begin
                    if (!r_lock) begin
                        // Unlocked: a single bad header means the alignment is wrong.
                        if (w_head_bad) begin
                            w_go_slip = 1'b1;
                        end else if (w_sh_cnt_inc == CNT_MAX) begin
                            w_lock_nxt      = 1'b1;
                            w_sh_cnt_nxt    = '0;
                            w_invld_cnt_nxt = '0;
                        end else begin
                            w_sh_cnt_nxt = w_sh_cnt_inc;
                        end
                    end else begin
                        // Locked: the invalid threshold is checked before the
                        // window end so it wins when both land on one header.
                        if (w_invld_inc == INVLD_MAX) begin
                            w_lock_nxt = 1'b0;
                            w_go_slip  = 1'b1;
                        end else if (w_sh_cnt_inc == CNT_MAX) begin
                            w_sh_cnt_nxt    = '0;
                            w_invld_cnt_nxt = '0;
                        end else begin
                            w_sh_cnt_nxt    = w_sh_cnt_inc;
                            w_invld_cnt_nxt = w_invld_inc;
                        end
                    end
                end
                // slip_o and the slip count are registered on entry to SLIP,
                // so the pulse is visible exactly during the SLIP cycle.
                if (w_go_slip) begin
                    w_state_nxt     = SLIP;
                    w_slip_nxt      = 1'b1;
                    w_sh_cnt_nxt    = '0;
                    w_invld_cnt_nxt = '0;
                    if (r_slip_cnt != '1) begin
                        w_slip_cnt_nxt = r_slip_cnt + SLIP_CNT_W'(1);
                    end
                end
            end
            SLIP: begin
                w_state_nxt     = WAIT;
                w_lock_nxt      = 1'b0;
                w_sh_cnt_nxt    = '0;
                w_invld_cnt_nxt = '0;
                w_wait_cnt_nxt  = '0;
            end
            WAIT: begin
                // Headers are ignored while the gearbox settles after a slip.
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt    = TEST;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                w_state_nxt = TEST;
            end
        endcase
    end

    assign slip_o       = r_slip;
    assign block_lock_o = r_lock;
    assign slip_cnt_o   = r_slip_cnt;

endmodule
